// File: rtl/dsa_pkg.sv
// Shared constants for the delay sample averager: default widths, state encodings, min-tracker init value.
package dsa_pkg;

    localparam int unsigned DSA_DATA_W       = 32;
    localparam int unsigned DSA_LOG2_SAMPLES = 4;
    localparam int unsigned DSA_SEL_W        = 5;
    localparam int unsigned DSA_TIMEOUT_CYC  = 4096;
    localparam int unsigned DSA_SUM_W        = DSA_DATA_W + DSA_LOG2_SAMPLES;

    localparam logic [DSA_DATA_W-1:0] DSA_MIN_INIT = '1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;
    localparam logic [1:0] ST_FINISH  = 2'd3;

endpackage

// File: rtl/delay_sample_avg_if.sv
// Bus between the delay mux / controller side (master) and the sample averager (slave).
interface delay_sample_avg_if
    import dsa_pkg::*;
#(
    parameter int unsigned DATA_W = DSA_DATA_W,
    parameter int unsigned SEL_W  = DSA_SEL_W
);

    logic [DATA_W-1:0] result;
    logic              fin;
    logic [SEL_W-1:0]  SW;
    logic              start;
    logic [DATA_W-1:0] threshold;
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] min_val;
    logic [DATA_W-1:0] max_val;
    logic              busy;
    logic              done;
    logic              alarm;
    logic              aborted;
    logic              timeout;

    modport master (
        output result, fin, SW, start, threshold,
        input  avg, min_val, max_val, busy, done, alarm, aborted, timeout
    );

    modport slave (
        input  result, fin, SW, start, threshold,
        output avg, min_val, max_val, busy, done, alarm, aborted, timeout
    );

endinterface

// File: rtl/dsa_stats.sv
// Running sum / min / max / sample-count datapath; cleared at run start, updated on each accepted sample.
module dsa_stats
    import dsa_pkg::*;
#(
    parameter int unsigned DATA_W       = DSA_DATA_W,
    parameter int unsigned LOG2_SAMPLES = DSA_LOG2_SAMPLES,
    parameter int unsigned SUM_W        = DSA_SUM_W
) (
    input  logic                    clk250,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    smp_i,
    input  logic [DATA_W-1:0]       sample_i,
    output logic [SUM_W-1:0]        sum_o,
    output logic [DATA_W-1:0]       min_o,
    output logic [DATA_W-1:0]       max_o,
    output logic [LOG2_SAMPLES-1:0] cnt_o
);

    logic [SUM_W-1:0]        sum_q;
    logic [DATA_W-1:0]       min_q;
    logic [DATA_W-1:0]       max_q;
    logic [LOG2_SAMPLES-1:0] cnt_q;

    // Accumulate one sample per enable; clear restores the empty-run values.
    always_ff @(posedge clk250 or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            min_q <= '1;
            max_q <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            sum_q <= '0;
            min_q <= '1;
            max_q <= '0;
            cnt_q <= '0;
        end else if (smp_i) begin
            sum_q <= sum_q + SUM_W'(sample_i);
            cnt_q <= cnt_q + LOG2_SAMPLES'(1);
            if (sample_i < min_q) begin
                min_q <= sample_i;
            end
            if (sample_i > max_q) begin
                max_q <= sample_i;
            end
        end
    end

    assign sum_o = sum_q;
    assign min_o = min_q;
    assign max_o = max_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/delay_sample_avg.sv
// Delay sample averager: collects 2**LOG2_SAMPLES fin-edge samples of the selected path, reports
// avg/min/max and a Trojan alarm when avg exceeds the golden threshold.
// Optional watchdog on fin edges enabled by defining DSA_TIMEOUT_EN.
module delay_sample_avg
    import dsa_pkg::*;
#(
    parameter int unsigned DATA_W       = DSA_DATA_W,
    parameter int unsigned LOG2_SAMPLES = DSA_LOG2_SAMPLES,
    parameter int unsigned SEL_W        = DSA_SEL_W,
    parameter int unsigned TIMEOUT_CYC  = DSA_TIMEOUT_CYC
) (
    input  logic               clk250,
    input  logic               rst,
    delay_sample_avg_if.slave  bus
);

    localparam int unsigned SUM_W = DATA_W + LOG2_SAMPLES;
    localparam logic [LOG2_SAMPLES-1:0] CNT_LAST = '1;

    // A zero-cycle watchdog is meaningless; reject it at elaboration.
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    logic [1:0]              state_q, state_d;
    logic                    fin_q;
    logic [SEL_W-1:0]        sw_q, sw_d;
    logic [DATA_W-1:0]       avg_q, avg_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    alarm_q, alarm_d;
    logic                    aborted_q, aborted_d;
    logic                    timeout_q, timeout_d;

    logic                    fin_edge_c;
    logic                    sw_chg_c;
    logic                    wd_exp_c;
    logic                    stats_clr_c;
    logic                    stats_smp_c;
    logic [DATA_W-1:0]       avg_next_c;

    logic [SUM_W-1:0]        sum_w;
    logic [DATA_W-1:0]       min_w;
    logic [DATA_W-1:0]       max_w;
    logic [LOG2_SAMPLES-1:0] cnt_w;

    assign fin_edge_c = bus.fin & ~fin_q;
    assign sw_chg_c   = (bus.SW != sw_q);
    assign avg_next_c = DATA_W'(sum_w >> LOG2_SAMPLES);

    dsa_stats #(
        .DATA_W       (DATA_W),
        .LOG2_SAMPLES (LOG2_SAMPLES),
        .SUM_W        (SUM_W)
    ) u_stats (
        .clk250   (clk250),
        .rst      (rst),
        .clr_i    (stats_clr_c),
        .smp_i    (stats_smp_c),
        .sample_i (bus.result),
        .sum_o    (sum_w),
        .min_o    (min_w),
        .max_o    (max_w),
        .cnt_o    (cnt_w)
    );

`ifdef DSA_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;

    assign wd_exp_c = (wd_q == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog: held clear while idle (so it starts at 0 on ARM entry) and on each accepted edge.
    always_ff @(posedge clk250 or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else if (state_q == ST_IDLE || stats_smp_c) begin
            wd_q <= '0;
        end else if ((state_q == ST_ARM || state_q == ST_COLLECT) && !wd_exp_c) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    assign wd_exp_c = 1'b0;
`endif

    // State, fin history, latched select and registered outputs.
    always_ff @(posedge clk250 or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fin_q     <= 1'b0;
            sw_q      <= '0;
            avg_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
            aborted_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fin_q     <= bus.fin;
            sw_q      <= sw_d;
            avg_q     <= avg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
            aborted_q <= aborted_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and output logic; abort outranks sampling and the watchdog.
    always_comb begin
        state_d     = state_q;
        sw_d        = sw_q;
        avg_d       = avg_q;
        done_d      = 1'b0;
        alarm_d     = alarm_q;
        aborted_d   = aborted_q;
        timeout_d   = timeout_q;
        stats_clr_c = 1'b0;
        stats_smp_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_ARM;
                    sw_d        = bus.SW;
                    stats_clr_c = 1'b1;
                    alarm_d     = 1'b0;
                    aborted_d   = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            ST_ARM: begin
                if (sw_chg_c) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                    alarm_d   = 1'b0;
                    done_d    = 1'b1;
                end else if (wd_exp_c) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    alarm_d   = 1'b0;
                    done_d    = 1'b1;
                end else if (!bus.fin) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (sw_chg_c) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                    alarm_d   = 1'b0;
                    done_d    = 1'b1;
                end else if (fin_edge_c) begin
                    stats_smp_c = 1'b1;
                    if (cnt_w == CNT_LAST) begin
                        state_d = ST_FINISH;
                    end
                end else if (wd_exp_c) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    alarm_d   = 1'b0;
                    done_d    = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                avg_d   = avg_next_c;
                alarm_d = (avg_next_c > bus.threshold);
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ARM) || (state_d == ST_COLLECT);
    end

    assign bus.avg     = avg_q;
    assign bus.min_val = min_w;
    assign bus.max_val = max_w;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.alarm   = alarm_q;
    assign bus.aborted = aborted_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_delay_sample_avg.sv
// Scoreboard bench for delay_sample_avg: stimulus pushes expected run results, a monitor checks each done.
module tb_delay_sample_avg;
    import dsa_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned L2   = 4;
    localparam int unsigned SW_W = 5;
    localparam int unsigned TO   = 64;

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] avg;
        logic [31:0] mn;
        logic [31:0] mx;
        logic        alarm;
        logic        aborted;
        logic        tmo;
        logic        chk_avg;
    } exp_t;

    logic clk250 = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   tests  = 0;
    int   fails  = 0;
    exp_t sbq[$];

    always #2 clk250 = ~clk250;
    always @(posedge clk250) cyc <= cyc + 1;

    delay_sample_avg_if #(.DATA_W(DW), .SEL_W(SW_W)) bus ();

    delay_sample_avg #(
        .DATA_W       (DW),
        .LOG2_SAMPLES (L2),
        .SEL_W        (SW_W),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk250 (clk250),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk250);
        #1;
    endtask

    task automatic push(input string nm, input int c, input logic [31:0] a, input logic [31:0] mn,
                        input logic [31:0] mx, input logic al, input logic ab, input logic tm,
                        input logic ca);
        exp_t e;
        e.name = nm; e.cyc = c; e.avg = a; e.mn = mn; e.mx = mx;
        e.alarm = al; e.aborted = ab; e.tmo = tm; e.chk_avg = ca;
        sbq.push_back(e);
    endtask

    task automatic do_start(input logic [4:0] sw);
        bus.SW    = sw;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] v);
        bus.result = v;
        bus.fin    = 1'b1;
        tick();
        bus.fin    = 1'b0;
        tick();
    endtask

    // Issue n edges (base + i*step); if n completes a run, push the expected result before the last edge.
    task automatic edges(input string nm, input int n, input logic [31:0] base, input logic [31:0] step,
                         input logic [31:0] eavg, input logic [31:0] emin, input logic [31:0] emax,
                         input logic ealarm, input logic poke);
        for (int i = 0; i < n; i++) begin
            if (i == 15) push(nm, cyc + 2, eavg, emin, emax, ealarm, 1'b0, 1'b0, 1'b1);
            if (poke && i == 7) begin
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end
            pulse(base + 32'(i) * step);
        end
    endtask

    // Monitor: every done must match the oldest expected run.
    always @(negedge clk250) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
                chk({e.name, "_busy"}, 32'(bus.busy), 32'd0);
                chk({e.name, "_min"}, bus.min_val, e.mn);
                chk({e.name, "_max"}, bus.max_val, e.mx);
                chk({e.name, "_alarm"}, 32'(bus.alarm), 32'(e.alarm));
                chk({e.name, "_aborted"}, 32'(bus.aborted), 32'(e.aborted));
                chk({e.name, "_timeout"}, 32'(bus.timeout), 32'(e.tmo));
                if (e.chk_avg) chk({e.name, "_avg"}, bus.avg, e.avg);
            end
        end
    end

    initial begin
        int s;
        bus.result    = '0;
        bus.fin       = 1'b0;
        bus.SW        = 5'd3;
        bus.start     = 1'b0;
        bus.threshold = '0;
        tick(); tick(); tick();

        // Reset values
        chk("rst_avg", bus.avg, 32'd0);
        chk("rst_min", bus.min_val, DSA_MIN_INIT);
        chk("rst_max", bus.max_val, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_flags", {29'd0, bus.alarm, bus.aborted, bus.timeout}, 32'd0);
        rst = 1'b0;
        tick();

        // 1) ramp 100..115: avg 107, threshold 200 -> no alarm
        bus.threshold = 32'd200;
        do_start(5'd3);
        chk("t1_busy_arm", 32'(bus.busy), 32'd1);
        tick();
        edges("t1", 16, 32'd100, 32'd1, 32'd107, 32'd100, 32'd115, 1'b0, 1'b0);
        tick(); tick();

        // 2) constant 300: strictly greater than 299 alarms, equal to 300 does not; SW changes with start
        bus.threshold = 32'd299;
        do_start(5'd7);
        tick();
        edges("t2a", 16, 32'd300, 32'd0, 32'd300, 32'd300, 32'd300, 1'b1, 1'b0);
        tick(); tick();
        bus.threshold = 32'd300;
        do_start(5'd7);
        tick();
        edges("t2b", 16, 32'd300, 32'd0, 32'd300, 32'd300, 32'd300, 1'b0, 1'b0);
        tick(); tick();

        // 3) SW 3->4 after 5 edges aborts with partial min/max
        bus.threshold = 32'd0;
        do_start(5'd3);
        tick();
        edges("t3p", 5, 32'd50, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        bus.SW = 5'd4;
        push("t3", cyc + 1, 32'd0, 32'd50, 32'd54, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        // SW change while idle must not produce a done
        bus.SW = 5'd9;
        tick(); tick(); tick();

        // 4) fin rising in ARM and held is not a sample; sampling starts after it drops and rises
        bus.threshold = 32'd80;
        do_start(5'd9);
        bus.result = 32'd9999;
        bus.fin    = 1'b1;
        tick(); tick(); tick();
        bus.fin    = 1'b0;
        tick(); tick();
        edges("t4", 16, 32'd10, 32'd10, 32'd85, 32'd10, 32'd160, 1'b1, 1'b0);
        tick(); tick();

        // 5) reset mid-run returns everything to reset values at once, no done
        bus.threshold = 32'd200;
        do_start(5'd3);
        tick();
        edges("t5p", 8, 32'd500, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_avg", bus.avg, 32'd0);
        chk("t5_rst_min", bus.min_val, DSA_MIN_INIT);
        chk("t5_rst_max", bus.max_val, 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_alarm", 32'(bus.alarm), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        // fresh run behaves like 1), with a start pulse mid-run that must be ignored
        do_start(5'd3);
        tick();
        edges("t5", 16, 32'd100, 32'd1, 32'd107, 32'd100, 32'd115, 1'b0, 1'b1);
        tick(); tick();

        // 6) no fin edges at all
        bus.threshold = 32'd0;
`ifdef DSA_TIMEOUT_EN
        s = cyc;
        push("t6", s + 1 + int'(TO), 32'd0, DSA_MIN_INIT, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_start(5'd3);
        repeat (80) tick();
`else
        s = cyc;
        do_start(5'd3);
        repeat (200) tick();
        chk("t6_busy_hold", 32'(bus.busy), 32'd1);
        chk("t6_no_timeout", 32'(bus.timeout), 32'd0);
        chk("t6_wait_cycles", 32'(cyc - s >= 200), 32'd1);
        bus.SW = 5'd4;
        push("t6", cyc + 1, 32'd0, DSA_MIN_INIT, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
`endif

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 200 && sbq.size() > 0; i++) tick();
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending runs expected 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
